// File: rtl/accu_sum_buffer.sv
// Sum buffer behind the 4-sample accumulator. It captures the unstallable sum strobes
// into a first-word-fall-through FIFO and offers them on a valid/ready handshake.
// The optional largest-accepted-sum tracker is built only when ACCU_BUF_MAX_EN is defined.
module accu_sum_buffer #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        sum_in,
  input  logic                     sum_valid,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     ovf_clr,
  output logic [DATA_W-1:0]        max_sum
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_q;
  logic              overflow_q;
  logic [7:0]        drop_cnt_q;

  logic full;
  logic pop;
  logic accept;
  logic drop;

  // Handshake: a sum leaves the FIFO at a rising edge where dout_valid && dout_ready.
  // dout_valid never depends on dout_ready, and dout_ready while empty is ignored.
  // sum_valid has no ready; a strobe is lost only when the FIFO is full and not popping.
  always_comb begin
    full   = (level_q == FULL_LVL);
    pop    = (level_q != '0) && dout_ready;
    accept = sum_valid && (!full || pop);
    drop   = sum_valid && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wr_ptr] <= sum_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !accept) level_q <= level_q - 1'b1;
    end
  end

  // A drop at the same edge as ovf_clr restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (ovf_clr)                 drop_cnt_q <= 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

`ifdef ACCU_BUF_MAX_EN
  logic [DATA_W-1:0] max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (ovf_clr) begin
      max_q <= accept ? sum_in : '0;
    end else if (accept && (sum_in > max_q)) begin
      max_q <= sum_in;
    end
  end

  assign max_sum = max_q;
`else
  assign max_sum = '0;
`endif

  assign dout       = mem[rd_ptr];
  assign dout_valid = (level_q != '0);
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
